// File: rtl/exec_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared types for the packet-execution dispatcher: per-lane
//                state, dispatcher FSM state and the job descriptor.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    // Descriptor field widths. The dispatcher's ADDR_W / TAG_W parameters
    // default to these and must stay equal to them.
    localparam int DESC_ADDR_W = 16;
    localparam int DESC_TAG_W  = 4;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_BUSY = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;

    typedef enum logic [1:0] {
        DISP_RUN   = 2'd0,
        DISP_DRAIN = 2'd1,
        DISP_LOAD  = 2'd2
    } disp_state_t;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] op_start;
        logic [DESC_TAG_W-1:0]  tag;
    } desc_t;

    // Width of a lane index; a single lane still needs one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_dispatcher_if
//  Description : Request, lane, completion and reconfiguration signals of the
//                dispatcher. 'slave' is the dispatcher side, 'master' is the
//                parser / executor-array side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_dispatcher_if #(
    parameter int NUM_LANES = 2,
    parameter int ADDR_W    = 16,
    parameter int TAG_W     = 4,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    // descriptor request
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [ADDR_W-1:0]    req_op_start_i;
    logic [TAG_W-1:0]     req_tag_i;
    // executor lanes
    logic [NUM_LANES-1:0] lane_start_o;
    logic [ADDR_W-1:0]    lane_op_start_o;
    logic [TAG_W-1:0]     lane_tag_o;
    logic [NUM_LANES-1:0] lane_done_i;
    // completion report
    logic                 done_valid_o;
    logic [LANE_W-1:0]    done_lane_o;
    logic [TAG_W-1:0]     done_tag_o;
    // op-table reconfiguration
    logic                 cfg_req_i;
    logic                 cfg_busy_o;
    logic                 mod_start_o;

    modport slave (
        input  req_valid_i, req_op_start_i, req_tag_i, lane_done_i, cfg_req_i,
        output req_ready_o, lane_start_o, lane_op_start_o, lane_tag_o,
               done_valid_o, done_lane_o, done_tag_o, cfg_busy_o, mod_start_o
    );

    modport master (
        output req_valid_i, req_op_start_i, req_tag_i, lane_done_i, cfg_req_i,
        input  req_ready_o, lane_start_o, lane_op_start_o, lane_tag_o,
               done_valid_o, done_lane_o, done_tag_o, cfg_busy_o, mod_start_o
    );
endinterface
`default_nettype wire

// File: rtl/exec_dispatcher_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : desc_fifo
//  Description : Synchronous descriptor FIFO, first-in first-out.
//                Ports: clk, rst (async, active-low), push/push_data,
//                pop/head, full, empty, count (occupancy).
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module desc_fifo
    import exec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire desc_t                  push_data,
    input  wire logic                   pop,
    output desc_t                       head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    desc_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/exec_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : exec_dispatcher
//  Description : Buffers execution descriptors and dispatches them round-robin
//                to idle executor lanes, serialises lane completions into one
//                report per cycle, and sequences op-table reconfiguration
//                (drain all lanes, then pulse mod_start to every executor).
//                Ports: clk, rst (async, active-low), bus (slave modport):
//                req_* descriptor handshake, lane_* start/done per executor,
//                done_* completion report, cfg_req/cfg_busy/mod_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_dispatcher
    import exec_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int QDEPTH    = 4,
    parameter int ADDR_W    = DESC_ADDR_W,
    parameter int TAG_W     = DESC_TAG_W
) (
    input  wire logic         clk,
    input  wire logic         rst,
    exec_dispatcher_if.slave  bus
);
    localparam int c_LANE_W = lane_idx_w(NUM_LANES);
    localparam int c_CNT_W  = $clog2(QDEPTH) + 1;

    // FIFO side
    desc_t                  w_push_desc;
    desc_t                  w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [c_CNT_W-1:0]     w_count;
    logic [c_CNT_W-1:0]     w_count_next;
    logic                   r_req_ready;

    // lanes
    lane_state_t            r_lane_state [NUM_LANES];
    logic [TAG_W-1:0]       r_lane_tag   [NUM_LANES];
    logic [c_LANE_W-1:0]    r_rr_ptr;
    logic [c_LANE_W-1:0]    w_grant;
    logic [c_LANE_W-1:0]    w_rr_next;
    logic                   w_any_idle;
    logic                   w_all_idle;
    logic                   w_rpt_valid;
    logic [c_LANE_W-1:0]    w_rpt_lane;
    logic                   w_dispatch;

    // FSM
    disp_state_t            r_state;
    disp_state_t            w_state_next;
    logic                   w_cfg_busy_next;
    logic                   w_mod_start_next;

    // registered outputs
    logic [NUM_LANES-1:0]   r_lane_start;
    logic [ADDR_W-1:0]      r_lane_op_start;
    logic [TAG_W-1:0]       r_lane_tag_out;
    logic                   r_done_valid;
    logic [c_LANE_W-1:0]    r_done_lane;
    logic [TAG_W-1:0]       r_done_tag;
    logic                   r_cfg_busy;
    logic                   r_mod_start;

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    assign w_push_desc.op_start = bus.req_op_start_i;
    assign w_push_desc.tag      = bus.req_tag_i;
    // Ready is registered, so it already excludes a full FIFO; the full
    // term only guards against a ready/full disagreement.
    assign w_push = bus.req_valid_i && r_req_ready && !w_full;
    assign w_pop  = w_dispatch;

    desc_fifo #(
        .DEPTH      (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (w_push_desc),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count)
    );

    // Occupancy after this edge; ready tracks it so a pop on a full FIFO
    // frees a slot only from the following cycle.
    always_comb begin
        w_count_next = w_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = w_count + 1'b1;
            2'b01:   w_count_next = w_count - 1'b1;
            default: w_count_next = w_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin grant: first IDLE lane at or above r_rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        logic [c_LANE_W-1:0] v_sel;
        v_sel      = '0;
        w_any_idle = 1'b0;
        w_grant    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            v_sel = c_LANE_W'((int'(r_rr_ptr) + i) % NUM_LANES);
            if (!w_any_idle && (r_lane_state[v_sel] == LANE_IDLE)) begin
                w_any_idle = 1'b1;
                w_grant    = v_sel;
            end
        end
        w_rr_next = (int'(w_grant) == NUM_LANES - 1) ? '0 : w_grant + 1'b1;
    end

    // ------------------------------------------------------------------
    // Completion picker: lowest-index DONE lane; descending scan keeps the
    // last (lowest) hit.
    // ------------------------------------------------------------------
    always_comb begin
        w_rpt_valid = 1'b0;
        w_rpt_lane  = '0;
        w_all_idle  = 1'b1;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_lane_state[i] != LANE_IDLE) begin
                w_all_idle = 1'b0;
            end
            if (r_lane_state[i] == LANE_DONE) begin
                w_rpt_valid = 1'b1;
                w_rpt_lane  = c_LANE_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reconfiguration FSM. A cfg request in RUN takes priority over a
    // dispatch in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DISP_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cfg_busy_next  = r_cfg_busy;
        w_mod_start_next = 1'b0;
        w_dispatch       = 1'b0;
        case (r_state)
            DISP_RUN: begin
                if (bus.cfg_req_i) begin
                    w_state_next    = DISP_DRAIN;
                    w_cfg_busy_next = 1'b1;
                end else begin
                    w_dispatch = !w_empty && w_any_idle;
                end
            end
            DISP_DRAIN: begin
                if (w_all_idle) begin
                    w_state_next = DISP_LOAD;
                end
            end
            DISP_LOAD: begin
                w_mod_start_next = 1'b1;
                w_cfg_busy_next  = 1'b0;
                w_state_next     = DISP_RUN;
            end
            default: begin
                w_state_next = DISP_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane state and tag. A done pulse only matters on a BUSY lane.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lane_state[i] <= LANE_IDLE;
                r_lane_tag[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                case (r_lane_state[i])
                    LANE_IDLE: begin
                        if (w_dispatch && (w_grant == c_LANE_W'(i))) begin
                            r_lane_state[i] <= LANE_BUSY;
                            r_lane_tag[i]   <= w_head.tag;
                        end
                    end
                    LANE_BUSY: begin
                        if (bus.lane_done_i[i]) begin
                            r_lane_state[i] <= LANE_DONE;
                        end
                    end
                    LANE_DONE: begin
                        if (w_rpt_valid && (w_rpt_lane == c_LANE_W'(i))) begin
                            r_lane_state[i] <= LANE_IDLE;
                        end
                    end
                    default: begin
                        r_lane_state[i] <= LANE_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready     <= 1'b0;
            r_rr_ptr        <= '0;
            r_lane_start    <= '0;
            r_lane_op_start <= '0;
            r_lane_tag_out  <= '0;
            r_done_valid    <= 1'b0;
            r_done_lane     <= '0;
            r_done_tag      <= '0;
            r_cfg_busy      <= 1'b0;
            r_mod_start     <= 1'b0;
        end else begin
            r_req_ready  <= (w_count_next != c_CNT_W'(QDEPTH));
            r_lane_start <= w_dispatch ? (NUM_LANES'(1) << w_grant) : '0;
            if (w_dispatch) begin
                r_lane_op_start <= w_head.op_start;
                r_lane_tag_out  <= w_head.tag;
                r_rr_ptr        <= w_rr_next;
            end
            r_done_valid <= w_rpt_valid;
            if (w_rpt_valid) begin
                r_done_lane <= w_rpt_lane;
                r_done_tag  <= r_lane_tag[w_rpt_lane];
            end
            r_cfg_busy  <= w_cfg_busy_next;
            r_mod_start <= w_mod_start_next;
        end
    end

    assign bus.req_ready_o     = r_req_ready;
    assign bus.lane_start_o    = r_lane_start;
    assign bus.lane_op_start_o = r_lane_op_start;
    assign bus.lane_tag_o      = r_lane_tag_out;
    assign bus.done_valid_o    = r_done_valid;
    assign bus.done_lane_o     = r_done_lane;
    assign bus.done_tag_o      = r_done_tag;
    assign bus.cfg_busy_o      = r_cfg_busy;
    assign bus.mod_start_o     = r_mod_start;
endmodule
`default_nettype wire

// File: tb/tb_exec_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_dispatcher
//  Description : Directed self-checking bench for exec_dispatcher with a
//                dispatch/completion scoreboard (2 lanes, 4-deep FIFO).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_dispatcher;
    localparam int NUM_LANES = 2;
    localparam int QDEPTH    = 4;
    localparam int ADDR_W    = 16;
    localparam int TAG_W     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exec_dispatcher_if #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

    exec_dispatcher #(
        .NUM_LANES (NUM_LANES),
        .QDEPTH    (QDEPTH),
        .ADDR_W    (ADDR_W),
        .TAG_W     (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  lanes;
        logic [15:0] op;
        logic [3:0]  tag;
    } disp_t;

    typedef struct {
        logic       lane;
        logic [3:0] tag;
    } done_t;

    disp_t exp_disp [$];
    done_t exp_done [$];
    disp_t m_d;
    done_t m_c;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one descriptor, record where it must be dispatched, return
    // just after the accepting edge.
    task automatic send(input logic [15:0] op, input logic [3:0] tag, input logic [1:0] lanes);
        int n;
        n = 0;
        exp_disp.push_back('{lanes, op, tag});
        bus.req_valid_i    = 1'b1;
        bus.req_op_start_i = op;
        bus.req_tag_i      = tag;
        while (bus.req_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_ready_timeout", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [1:0] m);
        bus.lane_done_i = m;
        tick();
        bus.lane_done_i = '0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_lane_start"}, bus.lane_start_o, 0);
        chk({name, "_lane_op"},    bus.lane_op_start_o, 0);
        chk({name, "_lane_tag"},   bus.lane_tag_o, 0);
        chk({name, "_done_valid"}, bus.done_valid_o, 0);
        chk({name, "_done_lane"},  bus.done_lane_o, 0);
        chk({name, "_done_tag"},   bus.done_tag_o, 0);
        chk({name, "_cfg_busy"},   bus.cfg_busy_o, 0);
        chk({name, "_mod_start"},  bus.mod_start_o, 0);
        chk({name, "_req_ready"},  bus.req_ready_o, 0);
    endtask

    // Scoreboard: every lane start and completion report is matched in order.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.lane_start_o !== '0) begin
                if (exp_disp.size() == 0) begin
                    chk("unexpected_dispatch", bus.lane_start_o, 0);
                end else begin
                    m_d = exp_disp.pop_front();
                    chk("disp_lane", bus.lane_start_o, m_d.lanes);
                    chk("disp_op",   bus.lane_op_start_o, m_d.op);
                    chk("disp_tag",  bus.lane_tag_o, m_d.tag);
                end
            end
            if (bus.done_valid_o !== 1'b0) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", bus.done_valid_o, 0);
                end else begin
                    m_c = exp_done.pop_front();
                    chk("done_lane", bus.done_lane_o, m_c.lane);
                    chk("done_tag",  bus.done_tag_o, m_c.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst                = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_op_start_i = '0;
        bus.req_tag_i      = '0;
        bus.lane_done_i    = '0;
        bus.cfg_req_i      = 1'b0;

        // ---------------- reset values and release ----------------
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        #1;
        chk("ready_before_first_edge", bus.req_ready_o, 0);
        tick();
        chk("ready_after_release", bus.req_ready_o, 1);

        // ---------------- 1: three descriptors, two lanes ----------------
        send(16'd0, 4'd1, 2'b01);
        send(16'd5, 4'd2, 2'b10);
        chk("t1_first_dispatch_latency", bus.lane_start_o, 2'b01);
        send(16'd9, 4'd3, 2'b01);
        chk("t1_second_dispatch", bus.lane_start_o, 2'b10);
        tick();
        chk("t1_third_waits", bus.lane_start_o, 0);
        exp_done.push_back('{1'b0, 4'd1});
        pulse_done(2'b01);
        chk("t1_done_not_yet", bus.done_valid_o, 0);
        tick();
        chk("t1_done_latency", bus.done_valid_o, 1);
        tick();
        chk("t1_redispatch_lane0", bus.lane_start_o, 2'b01);

        // ---------------- 3: simultaneous completions ----------------
        exp_done.push_back('{1'b0, 4'd3});
        exp_done.push_back('{1'b1, 4'd2});
        pulse_done(2'b11);
        tick();
        chk("t3_first_valid", bus.done_valid_o, 1);
        chk("t3_first_lane",  bus.done_lane_o, 0);
        chk("t3_first_tag",   bus.done_tag_o, 3);
        tick();
        chk("t3_second_valid", bus.done_valid_o, 1);
        chk("t3_second_lane",  bus.done_lane_o, 1);
        chk("t3_second_tag",   bus.done_tag_o, 2);
        tick();
        chk("t3_reports_end", bus.done_valid_o, 0);

        // ---------------- 2: fill FIFO, back-pressure ----------------
        send(16'h10, 4'd4, 2'b10);
        send(16'h11, 4'd5, 2'b01);
        send(16'h12, 4'd6, 2'b10);
        send(16'h13, 4'd7, 2'b01);
        send(16'h14, 4'd8, 2'b10);
        send(16'h15, 4'd9, 2'b01);
        chk("t2_full_ready_low", bus.req_ready_o, 0);
        exp_disp.push_back('{2'b10, 16'h16, 4'd10});
        bus.req_valid_i    = 1'b1;
        bus.req_op_start_i = 16'h16;
        bus.req_tag_i      = 4'd10;
        tick();
        chk("t2_held_1", bus.req_ready_o, 0);
        tick();
        chk("t2_held_2", bus.req_ready_o, 0);
        exp_done.push_back('{1'b1, 4'd4});
        pulse_done(2'b10);
        chk("t2_held_3", bus.req_ready_o, 0);
        tick();
        chk("t2_held_4", bus.req_ready_o, 0);
        tick();
        chk("t2_pop_dispatch", bus.lane_start_o, 2'b10);
        chk("t2_ready_after_pop", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;
        chk("t2_fifth_accepted_full_again", bus.req_ready_o, 0);

        // ---------------- 4: reconfiguration with busy lanes ----------------
        bus.cfg_req_i = 1'b1;
        tick();
        bus.cfg_req_i = 1'b0;
        chk("t4_cfg_busy_set", bus.cfg_busy_o, 1);
        exp_done.push_back('{1'b0, 4'd5});
        pulse_done(2'b01);
        tick();
        tick();
        chk("t4_drain_no_dispatch_1", bus.lane_start_o, 0);
        chk("t4_drain_no_mod", bus.mod_start_o, 0);
        tick();
        chk("t4_drain_no_dispatch_2", bus.lane_start_o, 0);
        chk("t4_drain_busy", bus.cfg_busy_o, 1);
        exp_done.push_back('{1'b1, 4'd6});
        pulse_done(2'b10);
        tick();
        chk("t4_mod_wait_report", bus.mod_start_o, 0);
        tick();
        chk("t4_mod_wait_load", bus.mod_start_o, 0);
        chk("t4_busy_in_load", bus.cfg_busy_o, 1);
        tick();
        chk("t4_mod_pulse", bus.mod_start_o, 1);
        chk("t4_busy_clear", bus.cfg_busy_o, 0);
        chk("t4_no_dispatch_with_mod", bus.lane_start_o, 0);
        tick();
        chk("t4_dispatch_resumes", bus.lane_start_o, 2'b01);
        chk("t4_mod_one_cycle", bus.mod_start_o, 0);
        tick();
        chk("t4_second_resume", bus.lane_start_o, 2'b10);

        // ---------------- 5: reset mid-operation ----------------
        @(negedge clk);
        #1;
        chk("t5_pre_reset_ready", bus.req_ready_o, 1);
        exp_disp.delete();
        exp_done.delete();
        rst = 1'b0;
        #1;
        check_all_zero("t5_async");
        tick();
        tick();
        chk("t5_hold_ready", bus.req_ready_o, 0);
        chk("t5_hold_lane_start", bus.lane_start_o, 0);
        rst = 1'b1;
        #1;
        chk("t5_ready_before_edge", bus.req_ready_o, 0);
        tick();
        chk("t5_ready_after_release", bus.req_ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_stale_done", bus.done_valid_o, 0);
            chk("t5_no_stale_dispatch", bus.lane_start_o, 0);
        end

        // ---------------- 6: spurious done on idle lane ----------------
        pulse_done(2'b01);
        tick();
        chk("t6_no_done_1", bus.done_valid_o, 0);
        tick();
        chk("t6_no_done_2", bus.done_valid_o, 0);

        // cfg request beats a same-cycle dispatch; lanes idle -> mod_start
        // two edges after the request edge
        send(16'h20, 4'd11, 2'b01);
        bus.cfg_req_i = 1'b1;
        tick();
        bus.cfg_req_i = 1'b0;
        chk("t6_cfg_wins", bus.lane_start_o, 0);
        chk("t6_cfg_busy", bus.cfg_busy_o, 1);
        tick();
        chk("t6_mod_not_yet", bus.mod_start_o, 0);
        tick();
        chk("t6_mod_pulse", bus.mod_start_o, 1);
        chk("t6_busy_clear", bus.cfg_busy_o, 0);
        tick();
        chk("t6_dispatch_after_load", bus.lane_start_o, 2'b01);
        exp_done.push_back('{1'b0, 4'd11});
        pulse_done(2'b01);

        // ---------------- drain scoreboard ----------------
        n = 0;
        while ((exp_disp.size() != 0 || exp_done.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("scoreboard_disp_empty", exp_disp.size(), 0);
        chk("scoreboard_done_empty", exp_done.size(), 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
